// File: rtl/exc_source_ctrl_pkg.sv
// Cause codes, source indices and FSM state encoding shared by exc_source_ctrl and its bench.
package exc_pkg;

  localparam logic [3:0] EXC_NONE   = 4'b0000;
  localparam logic [3:0] EXC_INVOP  = 4'b0001;
  localparam logic [3:0] EXC_EXTIRQ = 4'b0010;
  localparam logic [3:0] EXC_TIMER  = 4'b0011;

  localparam int NUM_SRC   = 3;
  localparam int SRC_INVOP = 0;
  localparam int SRC_EXT   = 1;
  localparam int SRC_TMR   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_e;

endpackage

// File: rtl/exc_source_ctrl_if.sv
// Event inputs and request/status outputs between the core and exc_source_ctrl.
interface exc_source_ctrl_if;
  import exc_pkg::*;

  logic               InvalidOp_D;
  logic               ExtIRQ;
  logic               ExcAck;
  logic               ERet;
  logic               Exc;
  logic [3:0]         EStatus;
  logic [NUM_SRC-1:0] Pending;
  logic               Overrun;

  modport master (
    output InvalidOp_D, ExtIRQ, ExcAck, ERet,
    input  Exc, EStatus, Pending, Overrun
  );

  modport slave (
    input  InvalidOp_D, ExtIRQ, ExcAck, ERet,
    output Exc, EStatus, Pending, Overrun
  );
endinterface

// File: rtl/exc_timer.sv
// Free-running 0..TIMER_PERIOD-1 counter; wrap_o is high in the cycle the count wraps to 0.
module exc_timer #(
  parameter int TIMER_PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic wrap_o
);

  localparam int CW = $clog2(TIMER_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(TIMER_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = (cnt_q == LAST);
    cnt_d  = wrap_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/exc_source_ctrl.sv
// Exception source controller: latches invop/ext/timer events, raises Exc by fixed priority.
// Optional internal timer source is built only when EXC_TIMER_EN is defined.
module exc_source_ctrl
  import exc_pkg::*;
#(
  parameter int TIMER_PERIOD = 1000
) (
  input logic              clk,
  input logic              reset,
  exc_source_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [3:0]         estatus_q, estatus_d;
  logic               ovr_q, ovr_d;
  logic               ext_q;

  logic               ext_evt;
  logic               tmr_evt;
  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] seen;
  logic               new_ovr;

  function automatic logic [3:0] prio_cause(input logic [NUM_SRC-1:0] src);
    logic [3:0] c;
    if (src[SRC_INVOP])    c = EXC_INVOP;
    else if (src[SRC_EXT]) c = EXC_EXTIRQ;
    else if (src[SRC_TMR]) c = EXC_TIMER;
    else                   c = EXC_NONE;
    return c;
  endfunction

  function automatic logic [NUM_SRC-1:0] cause_mask(input logic [3:0] cause);
    logic [NUM_SRC-1:0] m;
    m            = '0;
    m[SRC_INVOP] = (cause == EXC_INVOP);
    m[SRC_EXT]   = (cause == EXC_EXTIRQ);
    m[SRC_TMR]   = (cause == EXC_TIMER);
    return m;
  endfunction

`ifdef EXC_TIMER_EN
  exc_timer #(
    .TIMER_PERIOD(TIMER_PERIOD)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .wrap_o(tmr_evt)
  );
`else
  logic unused_period;
  assign unused_period = |TIMER_PERIOD;
  assign tmr_evt       = 1'b0;
`endif

  always_comb begin
    ext_evt        = bus.ExtIRQ & ~ext_q;
    evt            = '0;
    evt[SRC_INVOP] = bus.InvalidOp_D;
    evt[SRC_EXT]   = ext_evt;
    evt[SRC_TMR]   = tmr_evt;

    // An ack retires only the cause being presented; a same-cycle refire of it wins.
    clr = '0;
    if (state_q == REQ && bus.ExcAck) clr = cause_mask(estatus_q);

    pend_d    = (pend_q & ~clr) | evt;
    new_ovr   = |(evt & pend_q & ~clr);
    ovr_d     = ovr_q | new_ovr;
    seen      = pend_q | evt;
    state_d   = state_q;
    estatus_d = estatus_q;

    case (state_q)
      IDLE: begin
        if (|seen) begin
          state_d   = REQ;
          estatus_d = prio_cause(seen);
        end
      end
      REQ: begin
        if (bus.ExcAck) state_d = HANDLER;
      end
      HANDLER: begin
        if (bus.ERet) begin
          state_d = IDLE;
          ovr_d   = new_ovr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      estatus_q <= EXC_NONE;
      ovr_q     <= 1'b0;
      ext_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      estatus_q <= estatus_d;
      ovr_q     <= ovr_d;
      ext_q     <= bus.ExtIRQ;
    end
  end

  assign bus.Exc     = (state_q == REQ);
  assign bus.EStatus = estatus_q;
  assign bus.Pending = pend_q;
  assign bus.Overrun = ovr_q;

endmodule

// File: tb/tb_exc_source_ctrl.sv
// Directed scenario bench for exc_source_ctrl with a queue of expected causes per request.
module tb_exc_source_ctrl;
  import exc_pkg::*;

`ifdef EXC_TIMER_EN
  localparam int TP = 8;
`else
  localparam int TP = 1000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_c;

  exc_source_ctrl_if bus();

  exc_source_ctrl #(.TIMER_PERIOD(TP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.InvalidOp_D = 1'b0;
    bus.ExtIRQ      = 1'b0;
    bus.ExcAck      = 1'b0;
    bus.ERet        = 1'b0;
  endtask

  task automatic pop_exp();
    exp_c = 4'bxxxx;
    if (exp_q.size() > 0) exp_c = exp_q.pop_front();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (bus.Exc !== 1'b0) begin n_bad++; $display("FAIL reset_exc got=%b want=0", bus.Exc); end
    n_cmp++; if (bus.EStatus !== EXC_NONE) begin n_bad++; $display("FAIL reset_estatus got=%b want=0000", bus.EStatus); end
    n_cmp++; if (bus.Pending !== 3'b000) begin n_bad++; $display("FAIL reset_pending got=%b want=000", bus.Pending); end
    n_cmp++; if (bus.Overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got=%b want=0", bus.Overrun); end
    tick();
    n_cmp++; if (bus.Exc !== 1'b0) begin n_bad++; $display("FAIL reset_quiet got=%b want=0", bus.Exc); end
  endtask

  task automatic test_invop();
    tick(); tick(); tick();
    bus.InvalidOp_D = 1'b1; exp_q.push_back(EXC_INVOP);
    tick();
    bus.InvalidOp_D = 1'b0;
    pop_exp();
    n_cmp++; if (bus.Exc !== 1'b1) begin n_bad++; $display("FAIL invop_exc got=%b want=1", bus.Exc); end
    n_cmp++; if (bus.EStatus !== exp_c) begin n_bad++; $display("FAIL invop_estatus got=%b want=%b", bus.EStatus, exp_c); end
    n_cmp++; if (bus.Pending !== 3'b001) begin n_bad++; $display("FAIL invop_pending got=%b want=001", bus.Pending); end
    tick(); tick();
    n_cmp++; if (bus.Exc !== 1'b1 || bus.EStatus !== EXC_INVOP) begin n_bad++; $display("FAIL invop_hold got=%b/%b want=1/0001", bus.Exc, bus.EStatus); end
    bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
    n_cmp++; if (bus.Exc !== 1'b0) begin n_bad++; $display("FAIL invop_ack_exc got=%b want=0", bus.Exc); end
    n_cmp++; if (bus.Pending !== 3'b000) begin n_bad++; $display("FAIL invop_ack_pending got=%b want=000", bus.Pending); end
    n_cmp++; if (bus.EStatus !== EXC_INVOP) begin n_bad++; $display("FAIL invop_handler_estatus got=%b want=0001", bus.EStatus); end
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    tick();
    n_cmp++; if (bus.Exc !== 1'b0) begin n_bad++; $display("FAIL invop_after_eret got=%b want=0", bus.Exc); end
  endtask

  task automatic test_priority();
    bus.InvalidOp_D = 1'b1; bus.ExtIRQ = 1'b1;
    exp_q.push_back(EXC_INVOP); exp_q.push_back(EXC_EXTIRQ);
    tick();
    bus.InvalidOp_D = 1'b0;
    pop_exp();
    n_cmp++; if (bus.Exc !== 1'b1 || bus.EStatus !== exp_c) begin n_bad++; $display("FAIL prio_first got=%b/%b want=1/%b", bus.Exc, bus.EStatus, exp_c); end
    n_cmp++; if (bus.Pending !== 3'b011) begin n_bad++; $display("FAIL prio_pending got=%b want=011", bus.Pending); end
    bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
    n_cmp++; if (bus.Pending !== 3'b010) begin n_bad++; $display("FAIL prio_ack_pending got=%b want=010", bus.Pending); end
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    n_cmp++; if (bus.Exc !== 1'b0) begin n_bad++; $display("FAIL prio_idle_gap got=%b want=0", bus.Exc); end
    tick();
    pop_exp();
    n_cmp++; if (bus.Exc !== 1'b1 || bus.EStatus !== exp_c) begin n_bad++; $display("FAIL prio_second got=%b/%b want=1/%b", bus.Exc, bus.EStatus, exp_c); end
    bus.ExtIRQ = 1'b0;
    bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
    n_cmp++; if (bus.Pending !== 3'b000) begin n_bad++; $display("FAIL prio_drained got=%b want=000", bus.Pending); end
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    tick();
  endtask

  task automatic test_ext_level();
    bus.InvalidOp_D = 1'b1; exp_q.push_back(EXC_INVOP);
    tick();
    bus.InvalidOp_D = 1'b0;
    pop_exp();
    n_cmp++; if (bus.EStatus !== exp_c) begin n_bad++; $display("FAIL lvl_first got=%b want=%b", bus.EStatus, exp_c); end
    bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
    bus.ExtIRQ = 1'b1; exp_q.push_back(EXC_EXTIRQ);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if (bus.Exc !== 1'b0) begin n_bad++; $display("FAIL lvl_no_exc cycle=%0d got=%b want=0", i, bus.Exc); end
    end
    bus.ExtIRQ = 1'b0;
    n_cmp++; if (bus.Pending !== 3'b010) begin n_bad++; $display("FAIL lvl_pending got=%b want=010", bus.Pending); end
    n_cmp++; if (bus.Overrun !== 1'b0) begin n_bad++; $display("FAIL lvl_overrun got=%b want=0", bus.Overrun); end
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    n_cmp++; if (bus.Exc !== 1'b0) begin n_bad++; $display("FAIL lvl_idle_gap got=%b want=0", bus.Exc); end
    tick();
    pop_exp();
    n_cmp++; if (bus.Exc !== 1'b1 || bus.EStatus !== exp_c) begin n_bad++; $display("FAIL lvl_second got=%b/%b want=1/%b", bus.Exc, bus.EStatus, exp_c); end
    bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    tick();
  endtask

  task automatic test_overrun();
    bus.InvalidOp_D = 1'b1; exp_q.push_back(EXC_INVOP);
    tick();
    bus.InvalidOp_D = 1'b0;
    pop_exp();
    n_cmp++; if (bus.EStatus !== exp_c) begin n_bad++; $display("FAIL ovr_first got=%b want=%b", bus.EStatus, exp_c); end
    bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
    bus.InvalidOp_D = 1'b1; exp_q.push_back(EXC_INVOP);
    tick();
    bus.InvalidOp_D = 1'b0;
    n_cmp++; if (bus.Overrun !== 1'b0 || bus.Pending !== 3'b001) begin n_bad++; $display("FAIL ovr_first_latch got=%b/%b want=0/001", bus.Overrun, bus.Pending); end
    tick();
    bus.InvalidOp_D = 1'b1; tick(); bus.InvalidOp_D = 1'b0;
    n_cmp++; if (bus.Overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got=%b want=1", bus.Overrun); end
    tick();
    n_cmp++; if (bus.Overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got=%b want=1", bus.Overrun); end
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    n_cmp++; if (bus.Overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got=%b want=0", bus.Overrun); end
    tick();
    pop_exp();
    n_cmp++; if (bus.Exc !== 1'b1 || bus.EStatus !== exp_c) begin n_bad++; $display("FAIL ovr_second got=%b/%b want=1/%b", bus.Exc, bus.EStatus, exp_c); end
    bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.InvalidOp_D = 1'b1; exp_q.push_back(EXC_INVOP);
    tick();
    bus.InvalidOp_D = 1'b0;
    pop_exp();
    n_cmp++; if (bus.EStatus !== exp_c) begin n_bad++; $display("FAIL b2b_first got=%b want=%b", bus.EStatus, exp_c); end
    bus.ExcAck = 1'b1; bus.InvalidOp_D = 1'b1; exp_q.push_back(EXC_INVOP);
    tick();
    bus.ExcAck = 1'b0; bus.InvalidOp_D = 1'b0;
    n_cmp++; if (bus.Exc !== 1'b0 || bus.Pending !== 3'b001 || bus.Overrun !== 1'b0) begin
      n_bad++; $display("FAIL b2b_set_wins got=%b/%b/%b want=0/001/0", bus.Exc, bus.Pending, bus.Overrun); end
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    tick();
    pop_exp();
    n_cmp++; if (bus.Exc !== 1'b1 || bus.EStatus !== exp_c) begin n_bad++; $display("FAIL b2b_second got=%b/%b want=1/%b", bus.Exc, bus.EStatus, exp_c); end
    bus.ExcAck = 1'b1; bus.ExtIRQ = 1'b1; exp_q.push_back(EXC_EXTIRQ);
    tick();
    bus.ExcAck = 1'b0;
    n_cmp++; if (bus.Pending !== 3'b010 || bus.Overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_other got=%b/%b want=010/0", bus.Pending, bus.Overrun); end
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    tick();
    pop_exp();
    n_cmp++; if (bus.Exc !== 1'b1 || bus.EStatus !== exp_c) begin n_bad++; $display("FAIL b2b_third got=%b/%b want=1/%b", bus.Exc, bus.EStatus, exp_c); end
    bus.ExtIRQ = 1'b0;
    bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    tick();
  endtask

  task automatic test_ignored();
    bus.ExcAck = 1'b1; bus.ERet = 1'b1; tick(); bus.ExcAck = 1'b0; bus.ERet = 1'b0;
    n_cmp++; if (bus.Exc !== 1'b0 || bus.Pending !== 3'b000) begin n_bad++; $display("FAIL ign_idle got=%b/%b want=0/000", bus.Exc, bus.Pending); end
    bus.InvalidOp_D = 1'b1; exp_q.push_back(EXC_INVOP);
    tick();
    bus.InvalidOp_D = 1'b0;
    pop_exp();
    n_cmp++; if (bus.EStatus !== exp_c) begin n_bad++; $display("FAIL ign_req got=%b want=%b", bus.EStatus, exp_c); end
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    n_cmp++; if (bus.Exc !== 1'b1) begin n_bad++; $display("FAIL ign_eret_in_req got=%b want=1", bus.Exc); end
    bus.ExcAck = 1'b1; tick(); tick(); bus.ExcAck = 1'b0;
    n_cmp++; if (bus.Exc !== 1'b0) begin n_bad++; $display("FAIL ign_ack_in_handler got=%b want=0", bus.Exc); end
    bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    tick();
    n_cmp++; if (bus.Exc !== 1'b0) begin n_bad++; $display("FAIL ign_final got=%b want=0", bus.Exc); end
  endtask

  task automatic test_reset_mid();
    bus.InvalidOp_D = 1'b1; bus.ExtIRQ = 1'b1;
    tick();
    bus.InvalidOp_D = 1'b0;
    n_cmp++; if (bus.Exc !== 1'b1 || bus.Pending !== 3'b011) begin n_bad++; $display("FAIL rmid_pre got=%b/%b want=1/011", bus.Exc, bus.Pending); end
    reset = 1'b1; bus.ExtIRQ = 1'b0;
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.Exc !== 1'b0 || bus.Pending !== 3'b000) begin n_bad++; $display("FAIL rmid_clear got=%b/%b want=0/000", bus.Exc, bus.Pending); end
    n_cmp++; if (bus.EStatus !== EXC_NONE || bus.Overrun !== 1'b0) begin n_bad++; $display("FAIL rmid_status got=%b/%b want=0000/0", bus.EStatus, bus.Overrun); end
    tick();
    n_cmp++; if (bus.Exc !== 1'b0) begin n_bad++; $display("FAIL rmid_discarded got=%b want=0", bus.Exc); end
  endtask

`ifdef EXC_TIMER_EN
  task automatic test_timer();
    int t_prev;
    int waited;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(EXC_TIMER);
      waited = 0;
      while (bus.Exc !== 1'b1 && waited < 20) begin tick(); waited++; end
      n_cmp++;
      if (bus.Exc !== 1'b1) begin
        n_bad++; $display("FAIL tmr_timeout req=%0d got=%b want=1", i, bus.Exc);
        void'(exp_q.pop_front());
      end else begin
        pop_exp();
        if (bus.EStatus !== exp_c) begin n_bad++; $display("FAIL tmr_estatus req=%0d got=%b want=%b", i, bus.EStatus, exp_c); end
        if (i > 0) begin
          n_cmp++; if (cyc - t_prev !== TP) begin n_bad++; $display("FAIL tmr_period req=%0d got=%0d want=%0d", i, cyc - t_prev, TP); end
        end
        t_prev = cyc;
      end
      bus.ExcAck = 1'b1; tick(); bus.ExcAck = 1'b0;
      bus.ERet = 1'b1; tick(); bus.ERet = 1'b0;
    end
  endtask
`else
  task automatic test_timer();
    for (int i = 0; i < 40; i++) begin
      tick();
      n_cmp++; if (bus.Exc !== 1'b0 || bus.Pending[2] !== 1'b0) begin
        n_bad++; $display("FAIL tmr_absent cycle=%0d got=%b/%b want=0/0", i, bus.Exc, bus.Pending[2]); end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
`ifndef EXC_TIMER_EN
    test_invop();
    test_priority();
    test_ext_level();
    test_overrun();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
`endif
    test_timer();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exc_source_ctrl.md
# exc_source_ctrl

Exception source controller sitting directly upstream of the exception unit. It collects exception events from the core (invalid opcode in Decode, external interrupt line, optional internal timer), latches them as pending, picks one by fixed priority, and drives the `Exc`/`EStatus` pair consumed by the exception unit. It holds the request until the exception unit acknowledges the vector fetch (`ExcAck`). It then masks new requests until the handler returns (`ERet`).

## Interface
- `TIMER_PERIOD`, default 1000: timer interrupt period in clock cycles. Legal range is 2..2^16. Used only with `EXC_TIMER_EN`.
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `InvalidOp_D`  in  1  single-cycle pulse from Decode: unrecognised opcode.
- `ExtIRQ`  in  1  external interrupt, level. Rising edge is the event.
- `ExcAck`  in  1  from exception unit: vector address reached fetch.
- `ERet`  in  1  ERET instruction executed.
- `Exc`  out  1  exception request to exception unit.
- `EStatus`  out  4  cause code of the current request.
- `Pending`  out  3  pending bits {timer, ext, invop}, for debug/CSR.
- `Overrun`  out  1  sticky: an event arrived while its source was already pending.

## Operation
- Reset values: `Exc`=0, `EStatus`=4'b0000, `Pending`=3'b000, `Overrun`=0, state IDLE, timer count 0, ExtIRQ edge register 0.
- Cause codes: invalid opcode 4'b0001, external IRQ 4'b0010, timer 4'b0011, none 4'b0000.
- Priority: invop > ext > timer.
- Event capture:
  - A pending bit sets when its event is seen, in any state.
  - An ExtIRQ event is `ExtIRQ & ~ExtIRQ_q`.
  - If an event hits a source already pending (and not being cleared that cycle), `Overrun` sets.
- State machine:
  - IDLE: if any pending bit is set, or any event occurs this cycle, go to REQ. `EStatus` registers the highest-priority cause over (pending | events).
  - REQ: `Exc`=1 and `EStatus` is held stable. On `ExcAck`, go to HANDLER and clear the pending bit for the cause in `EStatus`.
  - HANDLER: `Exc`=0 and new events only latch. On `ERet`, go to IDLE; `Overrun` clears.
- `EStatus` keeps its last value in HANDLER and IDLE. It changes only on the IDLE→REQ transition.
- Ignored inputs: `ExcAck` outside REQ, and `ERet` outside HANDLER.
- Same cycle set and clear of one source (ack while the same source fires again): set wins. The bit stays pending. This is a new occurrence, not an overrun.
- ExcAck plus a different new event in the same cycle: the new event latches, and the acked cause clears.

## Timing
- Event sampled at edge k → `Exc`=1 with a valid `EStatus` after edge k (visible in cycle k+1). Latency is 1 cycle from IDLE.
- `ExcAck` sampled at edge k → `Exc`=0 in cycle k+1.
- `ERet` sampled at edge k → IDLE in cycle k+1. If anything is pending, REQ in cycle k+2.
- Minimum gap between two requests: 1 IDLE cycle.
- Reset mid-operation (any state): next cycle all reset values apply. Pending events are discarded.

## Configuration
- `EXC_TIMER_EN` defined:
  - Counter runs 0..TIMER_PERIOD-1 in every state and wraps to 0.
  - The wrap cycle is a timer event.
- Undefined:
  - No counter is built and `TIMER_PERIOD` is unused.
  - `Pending[2]` is tied to 0 and code 4'b0011 is never produced.

## Structure
- Package `exc_pkg`:
  - cause-code localparams (`EXC_NONE`, `EXC_INVOP`, `EXC_EXTIRQ`, `EXC_TIMER`);
  - state enum {IDLE, REQ, HANDLER}.
- Sub-module `exc_timer` (counter plus wrap pulse) is instantiated only under `EXC_TIMER_EN`.
- Priority encoder, edge detect and FSM stay in the top module.

## Test plan
- Reset, then `InvalidOp_D` pulse at cycle 5 → `Exc`=1, `EStatus`=4'b0001 from cycle 6. `ExcAck` at cycle 9 → `Exc`=0 at cycle 10, `Pending`=000.
- `InvalidOp_D` and `ExtIRQ` rise in the same cycle → `EStatus`=0001. After ack, then `ERet` → second request with `EStatus`=0010 two cycles after `ERet`.
- `ExtIRQ` held high 20 cycles during HANDLER → exactly one ext pending. `Overrun` stays 0, and no `Exc` until `ERet`.
- Second `InvalidOp_D` while invop is already pending in HANDLER → `Overrun`=1, cleared the cycle after `ERet`.
- `EXC_TIMER_EN`, `TIMER_PERIOD`=8, no other events → `Exc` with `EStatus`=0011 every 8 cycles while each request is acked and returned promptly. Undefined: `Exc` is never raised.
- `reset` asserted while in REQ with 2 bits pending → next cycle `Exc`=0, `Pending`=000, `EStatus`=0000.
